pc_sequencer: RTL and testbench

//   Owns the program counter of the single-cycle RV32I core and decides when and where it advances.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program counter owner for the single-cycle RV32I core. Chooses the next PC
//   from pc+4, a branch target or a jump target. Commits only when the datapath
//   is not stalled. Traps misaligned or out-of-range targets into FAULT. Supports
//   debug halt, single step and resume, and counts retired instructions.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall_in          datapath cannot complete the current instruction
//   branch_taken/_target, jump/jump_target   next-PC sources (jump has priority)
//   dbg_halt_req      level halt request; dbg_step_req / dbg_resume_req pulses
//   fault_clear       acknowledge fault, restart at TRAP_VECTOR
//   inst_address      current PC; pc_plus4 = inst_address + 4 (combinational)
//   instr_valid       current instruction commits this cycle
//   dbg_halted, fault status flags; fault_addr / fault_cause captured on fault
//   instret           retired-instruction counter
module pc_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_SIZE      = 256,
  parameter int RESET_VECTOR  = 0,
  parameter int TRAP_VECTOR   = 0,
  parameter bit START_HALTED  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_in,
  input  logic                     branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  input  logic                     jump,
  input  logic [ADDRESS_WIDTH-1:0] jump_target,
  input  logic                     dbg_halt_req,
  input  logic                     dbg_step_req,
  input  logic                     dbg_resume_req,
  input  logic                     fault_clear,
  output logic [ADDRESS_WIDTH-1:0] inst_address,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     instr_valid,
  output logic                     dbg_halted,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] fault_addr,
  output logic [1:0]               fault_cause,
  output logic [31:0]              instret
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC  = ADDRESS_WIDTH'(4 * MEM_SIZE - 4);
  localparam logic [ADDRESS_WIDTH-1:0] RST_PC   = ADDRESS_WIDTH'(RESET_VECTOR);
  localparam logic [ADDRESS_WIDTH-1:0] TRAP_PC  = ADDRESS_WIDTH'(TRAP_VECTOR);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_HALTED = 3'd2,
    S_STEP   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]              instret_q, instret_d;
  logic [ADDRESS_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [1:0]               fault_cause_q, fault_cause_d;

  logic [ADDRESS_WIDTH-1:0] seq_pc;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [1:0]               target_cause;
  logic                     target_bad;
  logic                     commit;

  // Fault cause encoding: bit0 = misaligned, bit1 = beyond the last word.
  function automatic logic [1:0] check_target(input logic [ADDRESS_WIDTH-1:0] t);
    logic [1:0] c;
    c[0] = (t[1:0] != 2'b00);
    c[1] = (t > LAST_PC);
    return c;
  endfunction

  assign seq_pc       = pc_q + ADDRESS_WIDTH'(4);
  assign target       = jump ? jump_target : (branch_taken ? branch_target : seq_pc);
  assign target_cause = check_target(target);
  assign target_bad   = (target_cause != 2'b00);

  // A halt request in RUN pre-empts the instruction; in STEP it is ignored.
  assign commit = ((state_q == S_RUN) || (state_q == S_STEP)) && !stall_in &&
                  !((state_q == S_RUN) && dbg_halt_req);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = START_HALTED ? S_HALTED : S_RUN;
      S_RUN: begin
        if (dbg_halt_req)            state_d = S_HALTED;
        else if (commit && target_bad) state_d = S_FAULT;
      end
      S_HALTED: begin
        if (dbg_step_req)        state_d = S_STEP;
        else if (dbg_resume_req) state_d = S_RUN;
      end
      S_STEP: begin
        if (commit) state_d = target_bad ? S_FAULT : S_HALTED;
      end
      S_FAULT: begin
        if (fault_clear) state_d = S_RUN;
      end
      default:  state_d = S_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    instr_valid = commit;
    dbg_halted  = (state_q == S_HALTED);
    fault       = (state_q == S_FAULT);
  end

  // PC / counter / fault capture next values
  always_comb begin
    pc_d          = pc_q;
    instret_d     = instret_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    if (commit) begin
      // The instruction retires even when its successor address traps.
      instret_d = instret_q + 32'd1;
      if (target_bad) begin
        fault_addr_d  = target;
        fault_cause_d = target_cause;
      end else begin
        pc_d = target;
      end
    end else if ((state_q == S_FAULT) && fault_clear) begin
      pc_d          = TRAP_PC;
      fault_cause_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RST_PC;
      instret_q     <= 32'd0;
      fault_addr_q  <= '0;
      fault_cause_q <= 2'b00;
    end else begin
      pc_q          <= pc_d;
      instret_q     <= instret_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign inst_address = pc_q;
  assign pc_plus4     = seq_pc;
  assign fault_addr   = fault_addr_q;
  assign fault_cause  = fault_cause_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        dbg_halt_req;
  logic        dbg_step_req;
  logic        dbg_resume_req;
  logic        fault_clear;
  logic [31:0] inst_address;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        dbg_halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  int checks = 0;
  int passed = 0;

  pc_sequencer #(
    .ADDRESS_WIDTH(32),
    .MEM_SIZE(256),
    .RESET_VECTOR(0),
    .TRAP_VECTOR(32'h100),
    .START_HALTED(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_in(stall_in),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .dbg_halt_req(dbg_halt_req),
    .dbg_step_req(dbg_step_req),
    .dbg_resume_req(dbg_resume_req),
    .fault_clear(fault_clear),
    .inst_address(inst_address),
    .pc_plus4(pc_plus4),
    .instr_valid(instr_valid),
    .dbg_halted(dbg_halted),
    .fault(fault),
    .fault_addr(fault_addr),
    .fault_cause(fault_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status snapshot: pc, instret, halted, fault
  task automatic chk_st(input string tag, input logic [31:0] pc, input logic [31:0] n,
                        input logic h, input logic f);
    chk({tag, ".pc"}, inst_address, pc);
    chk({tag, ".instret"}, instret, n);
    chk({tag, ".halted"}, {31'd0, dbg_halted}, {31'd0, h});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; dbg_halt_req = 1'b0; dbg_step_req = 1'b0;
    dbg_resume_req = 1'b0; fault_clear = 1'b0;

    // Reset state
    tick();
    chk_st("reset", 32'h0, 32'd0, 1'b0, 1'b0);
    chk("reset.valid", {31'd0, instr_valid}, 32'd0);
    chk("reset.cause", {30'd0, fault_cause}, 32'd0);
    chk("reset.faddr", fault_addr, 32'h0);
    rst = 1'b0;

    // BOOT lasts one cycle with no commit
    chk("boot.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_st("run0", 32'h0, 32'd0, 1'b0, 1'b0);
    chk("run0.valid", {31'd0, instr_valid}, 32'd1);
    tick(); chk_st("seq1", 32'h4, 32'd1, 1'b0, 1'b0);
    tick(); chk_st("seq2", 32'h8, 32'd2, 1'b0, 1'b0);
    tick(); chk_st("seq3", 32'hC, 32'd3, 1'b0, 1'b0);
    tick(); chk_st("seq4", 32'h10, 32'd4, 1'b0, 1'b0);

    // Jump has priority over a taken branch
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    #1 chk("jmp.pc_plus4", pc_plus4, 32'h14);
    tick(); chk_st("jmp", 32'h40, 32'd5, 1'b0, 1'b0);
    jump = 1'b0; branch_taken = 1'b0;

    // Stall holds PC and suppresses commit
    stall_in = 1'b1;
    #1 chk("stall.valid", {31'd0, instr_valid}, 32'd0);
    tick(); chk_st("stall", 32'h40, 32'd5, 1'b0, 1'b0);
    stall_in = 1'b0;

    // Sequential fall-off the end of memory
    jump = 1'b1; jump_target = 32'h3FC;
    tick(); chk_st("tolast", 32'h3FC, 32'd6, 1'b0, 1'b0);
    jump = 1'b0;
    #1 chk("last.pc_plus4", pc_plus4, 32'h400);
    tick();
    chk_st("oor", 32'h3FC, 32'd7, 1'b0, 1'b1);
    chk("oor.cause", {30'd0, fault_cause}, 32'd2);
    chk("oor.faddr", fault_addr, 32'h400);
    chk("oor.valid", {31'd0, instr_valid}, 32'd0);
    dbg_step_req = 1'b1; dbg_resume_req = 1'b1;
    tick(); chk_st("fault.dbgign", 32'h3FC, 32'd7, 1'b0, 1'b1);
    dbg_step_req = 1'b0; dbg_resume_req = 1'b0;
    fault_clear = 1'b1;
    tick();
    chk_st("clr1", 32'h100, 32'd7, 1'b0, 1'b0);
    chk("clr1.cause", {30'd0, fault_cause}, 32'd0);
    chk("clr1.faddr", fault_addr, 32'h400);
    fault_clear = 1'b0;

    // Misaligned branch target
    branch_taken = 1'b1; branch_target = 32'h22;
    tick();
    chk_st("mis", 32'h100, 32'd8, 1'b0, 1'b1);
    chk("mis.cause", {30'd0, fault_cause}, 32'd1);
    chk("mis.faddr", fault_addr, 32'h22);
    branch_taken = 1'b0; fault_clear = 1'b1;
    tick(); chk_st("clr2", 32'h100, 32'd8, 1'b0, 1'b0);
    fault_clear = 1'b0;

    // Misaligned and out of range together
    jump = 1'b1; jump_target = 32'h402;
    tick();
    chk_st("both", 32'h100, 32'd9, 1'b0, 1'b1);
    chk("both.cause", {30'd0, fault_cause}, 32'd3);
    chk("both.faddr", fault_addr, 32'h402);
    jump = 1'b0; fault_clear = 1'b1;
    tick(); chk_st("clr3", 32'h100, 32'd9, 1'b0, 1'b0);
    fault_clear = 1'b0;

    // Halt at 0x20, step through a 3-cycle stall, resume
    jump = 1'b1; jump_target = 32'h20;
    tick(); chk_st("to20", 32'h20, 32'd10, 1'b0, 1'b0);
    jump = 1'b0; dbg_halt_req = 1'b1;
    #1 chk("halt.valid", {31'd0, instr_valid}, 32'd0);
    tick(); chk_st("halted", 32'h20, 32'd10, 1'b1, 1'b0);
    dbg_halt_req = 1'b0; dbg_step_req = 1'b1; stall_in = 1'b1;
    tick(); chk_st("step.s1", 32'h20, 32'd10, 1'b0, 1'b0);
    dbg_step_req = 1'b0;
    chk("step.s1.valid", {31'd0, instr_valid}, 32'd0);
    tick(); chk_st("step.s2", 32'h20, 32'd10, 1'b0, 1'b0);
    tick(); chk_st("step.s3", 32'h20, 32'd10, 1'b0, 1'b0);
    stall_in = 1'b0;
    #1 chk("step.valid", {31'd0, instr_valid}, 32'd1);
    tick(); chk_st("step.done", 32'h24, 32'd11, 1'b1, 1'b0);
    tick(); chk_st("step.hold", 32'h24, 32'd11, 1'b1, 1'b0);
    dbg_resume_req = 1'b1;
    tick(); chk_st("resume", 32'h24, 32'd11, 1'b0, 1'b0);
    dbg_resume_req = 1'b0;
    tick(); chk_st("resume.run", 32'h28, 32'd12, 1'b0, 1'b0);

    // Resume while halt request is still high: one RUN cycle, no commit, then HALTED
    dbg_halt_req = 1'b1;
    tick(); chk_st("h2", 32'h28, 32'd12, 1'b1, 1'b0);
    dbg_resume_req = 1'b1;
    tick(); chk_st("h2.resume", 32'h28, 32'd12, 1'b0, 1'b0);
    chk("h2.valid", {31'd0, instr_valid}, 32'd0);
    dbg_resume_req = 1'b0;
    tick(); chk_st("h2.rehalt", 32'h28, 32'd12, 1'b1, 1'b0);
    dbg_halt_req = 1'b0;

    // Reset while in STEP with stall high
    dbg_step_req = 1'b1; stall_in = 1'b1;
    tick(); chk_st("step2", 32'h28, 32'd12, 1'b0, 1'b0);
    dbg_step_req = 1'b0; rst = 1'b1;
    tick();
    chk_st("rst.step", 32'h0, 32'd0, 1'b0, 1'b0);
    chk("rst.step.valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0; stall_in = 1'b0;
    chk("rst.boot.valid", {31'd0, instr_valid}, 32'd0);
    tick(); chk_st("rst.run", 32'h0, 32'd0, 1'b0, 1'b0);
    tick(); chk_st("rst.run1", 32'h4, 32'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
